// File: rtl/nco_sched.sv
// rtl/nco_sched.sv - phase-accumulator sequencer for the oscillator state RAM
// Sweeps every slot through a read-modify-write pipeline once per frame; applies single-slot updates between sweeps.
module nco_sched #(
  parameter int VOICES = 32,
  parameter int V_OSC  = 8,
  parameter int ADDR_W = $clog2(VOICES) + $clog2(V_OSC)
) (
  input  logic              sCLK_XVXENVS,
  input  logic              reset_reg_N,
  input  logic              frame_start,
  input  logic              upd_req,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [23:0]       upd_inc,
  input  logic              upd_rst,
  output logic              upd_ack,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [50:0]       rd_q,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [50:0]       wr_data,
  output logic              wr_en,
  output logic [25:0]       phase_out,
  output logic [ADDR_W-1:0] phase_slot,
  output logic              phase_valid,
  output logic              busy,
  output logic              overrun
);
  localparam int N = VOICES * V_OSC;
  localparam logic [ADDR_W-1:0] LAST_SLOT  = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(4);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_SWEEP, S_UPD, S_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  logic              s1_vld, s1_upd, s2_vld, s2_upd, s3_vld;
  logic [ADDR_W-1:0] s1_addr, s2_addr;
  logic [50:0]       s3_data;
  logic [23:0]       upd_inc_l;
  logic              upd_rst_l;
  logic [25:0]       sum_ph, new_ph;
  logic [50:0]       new_word;
  logic              take_upd;

  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt restarts at zero on every state change; it indexes INIT writes, sweep reads and DRAIN cycles
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (cnt == LAST_SLOT) state_nxt = S_DRAIN;
      S_IDLE: begin
        if (frame_start)  state_nxt = S_SWEEP;
        else if (upd_req) state_nxt = S_UPD;
      end
      S_SWEEP: if (cnt == LAST_SLOT) state_nxt = S_DRAIN;
      S_UPD:   state_nxt = S_DRAIN;
      S_DRAIN: if (cnt == DRAIN_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
    cnt_nxt  = (state_nxt != state) ? '0 : cnt + ADDR_W'(1);
    take_upd = (state == S_IDLE) && (state_nxt == S_UPD);
  end

  always_comb begin
    sum_ph = rd_q[49:24] + {2'b00, rd_q[23:0]};
    new_ph = rd_q[50] ? '0 : sum_ph;
    if (s2_upd) new_word = {upd_rst_l | rd_q[50], rd_q[49:24], upd_inc_l};
    else        new_word = {1'b0, new_ph, rd_q[23:0]};
  end

  // rd_q for the read issued in cycle t is consumed by stage 2 in cycle t+2
  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      busy        <= 1'b1;
      overrun     <= 1'b0;
      upd_ack     <= 1'b0;
      upd_inc_l   <= '0;
      upd_rst_l   <= 1'b0;
      rd_addr     <= '0;
      s1_vld      <= 1'b0;
      s1_upd      <= 1'b0;
      s1_addr     <= '0;
      s2_vld      <= 1'b0;
      s2_upd      <= 1'b0;
      s2_addr     <= '0;
      s3_vld      <= 1'b0;
      s3_data     <= '0;
      phase_valid <= 1'b0;
      phase_out   <= '0;
      phase_slot  <= '0;
      wr_addr     <= '0;
      wr_en       <= 1'b0;
      wr_data     <= '0;
    end else begin
      busy    <= (state_nxt != S_IDLE);
      overrun <= overrun | (frame_start & (state != S_IDLE));
      upd_ack <= take_upd;
      if (take_upd) begin
        upd_inc_l <= upd_inc;
        upd_rst_l <= upd_rst;
      end
      if (state_nxt == S_SWEEP)    rd_addr <= cnt_nxt;
      else if (state_nxt == S_UPD) rd_addr <= upd_addr;
      s1_vld  <= (state == S_SWEEP) || (state == S_UPD);
      s1_upd  <= (state == S_UPD);
      s1_addr <= rd_addr;
      s2_vld  <= s1_vld;
      s2_upd  <= s1_upd;
      s2_addr <= s1_addr;
      phase_valid <= s2_vld & ~s2_upd;
      if (s2_vld & ~s2_upd) begin
        phase_out  <= new_ph;
        phase_slot <= s2_addr;
      end
      s3_vld  <= s2_vld;
      s3_data <= new_word;
      if (state_nxt == S_INIT) wr_addr <= cnt_nxt;
      else if (s2_vld)         wr_addr <= s2_addr;
      wr_en   <= (state == S_INIT) | s3_vld;
      wr_data <= (state == S_INIT) ? '0 : s3_data;
    end
  end
endmodule

// File: tb/tb_nco_sched.sv
// tb/tb_nco_sched.sv - randomized self-checking bench for nco_sched
// Holds the state RAM itself and a word-level model of every slot; expected phases are queued per sweep.
`timescale 1ns/1ps
module tb_nco_sched;
  localparam int N  = 256;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          frame_start = 1'b0;
  logic          upd_req = 1'b0;
  logic [AW-1:0] upd_addr = '0;
  logic [23:0]   upd_inc = '0;
  logic          upd_rst = 1'b0;
  logic          upd_ack;
  logic [AW-1:0] rd_addr;
  logic [50:0]   rd_q;
  logic [AW-1:0] wr_addr;
  logic [50:0]   wr_data;
  logic          wr_en;
  logic [25:0]   phase_out;
  logic [AW-1:0] phase_slot;
  logic          phase_valid;
  logic          busy;
  logic          overrun;

  nco_sched dut (
    .sCLK_XVXENVS(clk), .reset_reg_N(rst_n), .frame_start(frame_start),
    .upd_req(upd_req), .upd_addr(upd_addr), .upd_inc(upd_inc), .upd_rst(upd_rst),
    .upd_ack(upd_ack), .rd_addr(rd_addr), .rd_q(rd_q), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_en(wr_en), .phase_out(phase_out), .phase_slot(phase_slot),
    .phase_valid(phase_valid), .busy(busy), .overrun(overrun)
  );

  typedef struct {
    int          cyc;
    int          slot;
    logic [25:0] ph;
  } exp_t;

  logic [50:0]   ram [N];
  logic [50:0]   mem_m [N];
  logic [25:0]   last_ph [N];
  logic [50:0]   q1;
  logic [AW-1:0] wa_d;
  logic          scr = 1'b0;
  logic          bd_en = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [50:0]   bd_data = '0;
  exp_t          exp_q[$];
  exp_t          e_cmp;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // two-cycle read latency; write address is captured one cycle ahead of data
  always @(posedge clk) begin
    q1   <= ram[rd_addr];
    rd_q <= q1;
    wa_d <= wr_addr;
    if (scr) for (int i = 0; i < N; i++) ram[i] <= 51'({$urandom(), $urandom()});
    if (wr_en) ram[wa_d] <= wr_data;
    if (bd_en) ram[bd_addr] <= bd_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (phase_valid) begin
      if (exp_q.size() == 0) begin
        check("phase_unexpected", 64'(phase_valid), 64'd0);
      end else begin
        e_cmp = exp_q.pop_front();
        check("phase_slot", 64'(phase_slot), 64'(e_cmp.slot));
        check("phase_value", 64'(phase_out), 64'(e_cmp.ph));
        check("phase_cycle", 64'(cyc), 64'(e_cmp.cyc));
        last_ph[phase_slot] = phase_out;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_sweep(input int c);
    logic [50:0] w;
    logic [25:0] ph;
    exp_t        x;
    for (int i = 0; i < N; i++) begin
      w  = mem_m[i];
      ph = w[50] ? 26'd0 : 26'(w[49:24] + w[23:0]);
      mem_m[i] = {1'b0, ph, w[23:0]};
      x.cyc  = c + 4 + i;
      x.slot = i;
      x.ph   = ph;
      exp_q.push_back(x);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_phase_valid"}, 64'(phase_valid), 64'd0);
    check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    check({tag, "_upd_ack"}, 64'(upd_ack), 64'd0);
    check({tag, "_overrun"}, 64'(overrun), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_addr_phase"}, {rd_addr, wr_addr, phase_slot, phase_out}, 64'd0);
    check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
  endtask

  task automatic ram_vs_model(input string name);
    int bad = 0;
    for (int i = 0; i < N; i++) if (ram[i] !== mem_m[i]) bad++;
    check(name, 64'(bad), 64'd0);
  endtask

  task automatic init_check();
    int bad = 0;
    int wen = 0;
    int nz  = 0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k <= N + 5; k++) begin
      @(negedge clk);
      if (k < N && wr_addr !== AW'(k)) bad++;
      if (wr_en !== (k >= 1 && k <= N)) bad++;
      if (wr_en) begin
        wen++;
        if (wr_data !== 51'd0) bad++;
      end
      if (busy !== (k < N + 5)) bad++;
      if (phase_valid || upd_ack) bad++;
    end
    check("init_sequence_errors", 64'(bad), 64'd0);
    check("init_write_count", 64'(wen), 64'(N));
    check("init_overrun", 64'(overrun), 64'd0);
    for (int i = 0; i < N; i++) begin
      if (ram[i] !== 51'd0) nz++;
      mem_m[i] = '0;
    end
    check("init_ram_zero", 64'(nz), 64'd0);
  endtask

  task automatic do_sweep();
    int c;
    int n = 0;
    tick();
    frame_start = 1'b1;
    c = cyc;
    model_sweep(c);
    tick();
    frame_start = 1'b0;
    do begin
      @(negedge clk);
      if (busy) n++;
    end while (busy && n < 400);
    check("sweep_busy_cycles", 64'(n), 64'(N + 5));
    check("sweep_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(busy), 64'd0);
  endtask

  task automatic do_upd(input int a, input logic [23:0] inc, input logic r, input int lat);
    int rc;
    int ack_c = -1;
    int n = 0;
    logic [50:0] w;
    tick();
    upd_req = 1'b1; upd_addr = AW'(a); upd_inc = inc; upd_rst = r;
    rc = cyc;
    while (ack_c < 0 && n < 2000) begin
      @(negedge clk);
      n++;
      if (upd_ack) ack_c = cyc;
    end
    check("upd_ack_seen", 64'(ack_c >= 0), 64'd1);
    if (lat > 0) check("upd_ack_latency", 64'(ack_c - rc), 64'(lat));
    w = mem_m[a];
    mem_m[a] = {r | w[50], w[49:24], inc};
    tick();
    upd_req = 1'b0;
    @(negedge clk);
    check("upd_ack_pulse", 64'(upd_ack), 64'd0);
    wait_idle("upd_idle");
  endtask

  task automatic backdoor(input int a, input logic [50:0] w);
    tick();
    bd_en = 1'b1; bd_addr = AW'(a); bd_data = w;
    mem_m[a] = w;
    tick();
    bd_en = 1'b0;
  endtask

  initial begin
    int c;
    int ack_c;
    int n;
    int pv;
    #1 rst_n = 1'b0;
    scr = 1'b1;
    tick();
    scr = 1'b0;
    chk_reset_vals("reset");
    init_check();

    do_upd(5, 24'h001000, 1'b0, 1);
    check("upd5_stored", 64'(ram[5]), 64'({1'b0, 26'd0, 24'h001000}));
    do_sweep();
    check("slot5_first", 64'(last_ph[5]), 64'h1000);
    check("slot0_zero", 64'(last_ph[0]), 64'd0);
    do_sweep();
    check("slot5_second", 64'(last_ph[5]), 64'h2000);
    check("slot200_zero", 64'(last_ph[200]), 64'd0);

    backdoor(7, {1'b0, 26'h3FFF800, 24'h001000});
    do_sweep();
    check("slot7_wrap", 64'(last_ph[7]), 64'h0000800);

    do_upd(3, 24'h000300, 1'b0, 1);
    do_sweep();
    do_sweep();
    check("slot3_accum", 64'(last_ph[3]), 64'h600);
    do_upd(3, 24'h000300, 1'b1, 1);
    check("slot3_flag_set", 64'(ram[3][50]), 64'd1);
    do_sweep();
    check("slot3_reset_phase", 64'(last_ph[3]), 64'd0);
    check("slot3_flag_clear", 64'(ram[3][50]), 64'd0);
    do_sweep();
    check("slot3_after_reset", 64'(last_ph[3]), 64'h300);

    // simultaneous frame_start and upd_req, plus a frame_start dropped mid-sweep
    tick();
    frame_start = 1'b1; upd_req = 1'b1; upd_addr = AW'(9); upd_inc = 24'h000040; upd_rst = 1'b0;
    c = cyc;
    model_sweep(c);
    tick();
    frame_start = 1'b0;
    repeat (50) tick();
    check("overrun_pre", 64'(overrun), 64'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    ack_c = -1;
    n = 0;
    while (ack_c < 0 && n < 600) begin
      @(negedge clk);
      n++;
      if (upd_ack) ack_c = cyc;
    end
    check("mixed_ack_cycle", 64'(ack_c), 64'(c + 1 + (N + 5) + 1));
    mem_m[9] = {mem_m[9][50], mem_m[9][49:24], 24'h000040};
    tick();
    upd_req = 1'b0;
    wait_idle("mixed_idle");
    check("overrun_sticky", 64'(overrun), 64'd1);
    check("mixed_drained", 64'(exp_q.size()), 64'd0);
    do_sweep();
    check("slot9_inc", 64'(last_ph[9]), 64'h40);
    ram_vs_model("ram_after_directed");

    for (int it = 0; it < 14; it++) begin
      case ($urandom_range(0, 2))
        0: do_upd($urandom_range(0, N - 1), 24'($urandom()), 1'($urandom_range(0, 1)), 1);
        1: backdoor($urandom_range(0, N - 1), 51'({$urandom(), $urandom()}));
        default: begin
          tick();
          frame_start = 1'b1;
          c = cyc;
          model_sweep(c);
          tick();
          frame_start = 1'b0;
          repeat ($urandom_range(1, 200)) tick();
          do_upd($urandom_range(0, N - 1), 24'($urandom()), 1'($urandom_range(0, 1)), 0);
          check("rand_mid_drained", 64'(exp_q.size()), 64'd0);
        end
      endcase
      do_sweep();
    end
    ram_vs_model("ram_after_random");

    // asynchronous reset while the sweep is reading slot 100
    tick();
    frame_start = 1'b1;
    c = cyc;
    model_sweep(c);
    tick();
    frame_start = 1'b0;
    while (cyc < c + 101) @(posedge clk);
    #3 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_vals("midreset");
    repeat (3) @(posedge clk);
    init_check();
    pv = 0;
    repeat (30) begin
      @(negedge clk);
      if (phase_valid) pv++;
    end
    check("no_phase_after_reset", 64'(pv), 64'd0);
    do_sweep();
    check("post_reset_slot100", 64'(last_ph[100]), 64'd0);
    ram_vs_model("ram_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end
endmodule
